// File: rtl/sd_spi_responder.sv
// sd_spi_responder
//   SD-card-side SPI responder (SPI mode 0). Answers the card initialization
//   sequence (CMD0, CMD8, CMD55/ACMD41, CMD58) and single-block writes
//   (CMD24). Each received block is delivered as a byte stream together with
//   its block address.
//
// Ports
//   clk210_p     in   system clock, at least 8x SCK
//   reset_n_p    in   asynchronous active-low reset
//   spi_sck_p    in   SPI clock from master (asynchronous)
//   spi_mosi_p   in   master-out data (asynchronous)
//   spi_ss_p     in   chip select, active-low (asynchronous)
//   spi_miso_p   out  slave-out data
//   wr_addr_p    out  argument of the last accepted CMD24
//   wr_data_p    out  received block data byte
//   wr_valid_p   out  one-cycle strobe per data byte
//   block_done_p out  one-cycle pulse after the last CRC byte of a block
//   init_done_p  out  high once the idle bit has cleared
module sd_spi_responder #(
    parameter int INIT_POLLS  = 2,
    parameter int NCR_BYTES   = 1,
    parameter int BUSY_BYTES  = 4,
    parameter int BLOCK_BYTES = 512
) (
    input  logic        clk210_p,
    input  logic        reset_n_p,
    input  logic        spi_sck_p,
    input  logic        spi_mosi_p,
    input  logic        spi_ss_p,
    output logic        spi_miso_p,
    output logic [31:0] wr_addr_p,
    output logic [7:0]  wr_data_p,
    output logic        wr_valid_p,
    output logic        block_done_p,
    output logic        init_done_p
);

    localparam logic [7:0]  POLL_INIT = 8'(INIT_POLLS);
    localparam logic [15:0] NCR_N     = 16'(NCR_BYTES);
    localparam logic [15:0] BUSY_N    = 16'(BUSY_BYTES);
    localparam logic [15:0] BLOCK_N   = 16'(BLOCK_BYTES);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_NCR, S_RESP, S_TOKEN, S_DATA, S_DRESP, S_BUSY
    } state_t;

    // Input synchronizers; edges are detected on the synchronized SCK.
    logic [1:0] sck_sync, mosi_sync, ss_sync;
    logic       sck_last;

    always_ff @(posedge clk210_p or negedge reset_n_p) begin
        if (!reset_n_p) begin
            sck_sync  <= 2'b00;
            mosi_sync <= 2'b11;
            ss_sync   <= 2'b11;
            sck_last  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[0], spi_sck_p};
            mosi_sync <= {mosi_sync[0], spi_mosi_p};
            ss_sync   <= {ss_sync[0], spi_ss_p};
            sck_last  <= sck_sync[1];
        end
    end

    logic sck_rise, sck_fall, ss_high;
    assign sck_rise = sck_sync[1] & ~sck_last;
    assign sck_fall = ~sck_sync[1] & sck_last;
    assign ss_high  = ss_sync[1];

    state_t      state;
    logic [2:0]  bit_cnt;
    logic [6:0]  rx_sr;
    logic [7:0]  tx_sr;
    logic [15:0] cnt;
    logic [5:0]  cmd_idx;
    logic [31:0] arg;
    logic [7:0]  r1_reg;
    logic [31:0] extra_sr;
    logic [2:0]  extra_left;
    logic        accepted;
    logic        idle, app;
    logic [7:0]  poll;

    logic [7:0] rx_byte;
    assign rx_byte = {rx_sr, mosi_sync[1]};

    // Command decode, evaluated against the fully collected argument and
    // committed when the CRC byte completes.
    logic        idle_nx, init_nx, illegal, accept;
    logic [7:0]  poll_nx, r1;
    logic [31:0] extra;
    logic [2:0]  extra_len;

    always_comb begin
        idle_nx   = idle;
        poll_nx   = poll;
        init_nx   = init_done_p;
        illegal   = 1'b0;
        accept    = 1'b0;
        extra     = 32'hFFFF_FFFF;
        extra_len = 3'd0;
        case (cmd_idx)
            6'd0: begin
                idle_nx = 1'b1;
                poll_nx = POLL_INIT;
                init_nx = 1'b0;
            end
            6'd8: begin
                extra     = {16'h0000, 8'h01, arg[7:0]};
                extra_len = 3'd4;
            end
            6'd55: ;
            6'd41: begin
                if (app) begin
                    poll_nx = (poll != 8'd0) ? poll - 8'd1 : 8'd0;
                    // Idle clears on the poll that reaches zero.
                    if (poll_nx == 8'd0) begin
                        idle_nx = 1'b0;
                        init_nx = 1'b1;
                    end
                end else begin
                    illegal = 1'b1;
                end
            end
            6'd58: begin
                extra     = 32'hC0FF_8000;
                extra_len = 3'd4;
            end
            6'd24: accept = ~idle;
            default: illegal = 1'b1;
        endcase
        r1 = {5'b00000, illegal, 1'b0, idle_nx};
    end

    always_ff @(posedge clk210_p or negedge reset_n_p) begin
        if (!reset_n_p) begin
            state        <= S_IDLE;
            bit_cnt      <= 3'd0;
            rx_sr        <= 7'd0;
            tx_sr        <= 8'hFF;
            cnt          <= 16'd0;
            cmd_idx      <= 6'd0;
            arg          <= 32'd0;
            r1_reg       <= 8'hFF;
            extra_sr     <= 32'hFFFF_FFFF;
            extra_left   <= 3'd0;
            accepted     <= 1'b0;
            idle         <= 1'b1;
            app          <= 1'b0;
            poll         <= POLL_INIT;
            spi_miso_p   <= 1'b1;
            wr_addr_p    <= 32'd0;
            wr_data_p    <= 8'd0;
            wr_valid_p   <= 1'b0;
            block_done_p <= 1'b0;
            init_done_p  <= 1'b0;
        end else begin
            wr_valid_p   <= 1'b0;
            block_done_p <= 1'b0;
            if (ss_high) begin
                // Deselect drops any partial transfer; card state is kept.
                bit_cnt    <= 3'd0;
                spi_miso_p <= 1'b1;
                tx_sr      <= 8'hFF;
                state      <= S_IDLE;
            end else begin
                if (sck_fall) begin
                    spi_miso_p <= tx_sr[7];
                    tx_sr      <= {tx_sr[6:0], 1'b1};
                end
                if (sck_rise) begin
                    rx_sr   <= rx_byte[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        // Byte complete: the next tx byte loads here and its
                        // MSB goes out on the following fall.
                        tx_sr <= 8'hFF;
                        case (state)
                            S_IDLE: begin
                                if (rx_byte[7:6] == 2'b01) begin
                                    cmd_idx <= rx_byte[5:0];
                                    cnt     <= 16'd0;
                                    state   <= S_CMD;
                                end
                            end
                            S_CMD: begin
                                if (cnt == 16'd4) begin
                                    // CRC byte: ignored, command executes now.
                                    idle        <= idle_nx;
                                    poll        <= poll_nx;
                                    init_done_p <= init_nx;
                                    app         <= (cmd_idx == 6'd55);
                                    if (accept)
                                        wr_addr_p <= arg;
                                    r1_reg      <= r1;
                                    extra_sr    <= extra;
                                    extra_left  <= extra_len;
                                    accepted    <= accept;
                                    cnt         <= 16'd1;
                                    state       <= S_NCR;
                                end else begin
                                    arg <= {arg[23:0], rx_byte};
                                    cnt <= cnt + 16'd1;
                                end
                            end
                            S_NCR: begin
                                if (cnt == NCR_N) begin
                                    tx_sr <= r1_reg;
                                    state <= S_RESP;
                                end else begin
                                    cnt <= cnt + 16'd1;
                                end
                            end
                            S_RESP: begin
                                if (extra_left != 3'd0) begin
                                    tx_sr      <= extra_sr[31:24];
                                    extra_sr   <= {extra_sr[23:0], 8'hFF};
                                    extra_left <= extra_left - 3'd1;
                                end else begin
                                    state <= accepted ? S_TOKEN : S_IDLE;
                                end
                            end
                            S_TOKEN: begin
                                if (rx_byte == 8'hFE) begin
                                    cnt   <= 16'd0;
                                    state <= S_DATA;
                                end
                            end
                            S_DATA: begin
                                if (cnt < BLOCK_N) begin
                                    wr_valid_p <= 1'b1;
                                    wr_data_p  <= rx_byte;
                                    cnt        <= cnt + 16'd1;
                                end else if (cnt == BLOCK_N) begin
                                    cnt <= cnt + 16'd1;
                                end else begin
                                    block_done_p <= 1'b1;
                                    tx_sr        <= 8'h05;
                                    state        <= S_DRESP;
                                end
                            end
                            S_DRESP: begin
                                tx_sr <= 8'h00;
                                cnt   <= 16'd1;
                                state <= S_BUSY;
                            end
                            S_BUSY: begin
                                if (cnt == BUSY_N) begin
                                    state <= S_IDLE;
                                end else begin
                                    tx_sr <= 8'h00;
                                    cnt   <= cnt + 16'd1;
                                end
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Testbench for sd_spi_responder: drives SPI mode-0 transactions as the
// master, checks response bytes from a queue of expected bytes and checks
// block data strobes against a scoreboard filled as data bytes are sent.
module tb_sd_spi_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sck = 1'b0;
    logic        mosi = 1'b1;
    logic        ss = 1'b1;
    logic        miso;
    logic [31:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        block_done;
    logic        init_done;

    sd_spi_responder dut (
        .clk210_p    (clk),
        .reset_n_p   (rst_n),
        .spi_sck_p   (sck),
        .spi_mosi_p  (mosi),
        .spi_ss_p    (ss),
        .spi_miso_p  (miso),
        .wr_addr_p   (wr_addr),
        .wr_data_p   (wr_data),
        .wr_valid_p  (wr_valid),
        .block_done_p(block_done),
        .init_done_p (init_done)
    );

    always #5 clk = ~clk;

    localparam int H = 4;   // clocks per SCK half period

    int n_checks = 0;
    int n_errors = 0;
    int strobes = 0;
    int dones = 0;
    int extra_strobes = 0;
    logic [7:0] wr_q[$];
    logic [7:0] resp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every strobe must match the oldest byte sent.
    always @(negedge clk) begin
        if (wr_valid) begin
            strobes++;
            if (wr_q.size() != 0) check("wr_data", {24'd0, wr_data}, {24'd0, wr_q.pop_front()});
            else extra_strobes++;
        end
        if (block_done) dones++;
    end

    task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            repeat (H) @(negedge clk);
            rx[i] = miso;
            sck = 1'b1;
            repeat (H) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] b);
        logic [7:0] r;
        spi_xfer(b, r);
    endtask

    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] a, input logic [7:0] crc);
        send({2'b01, idx});
        send(a[31:24]);
        send(a[23:16]);
        send(a[15:8]);
        send(a[7:0]);
        send(crc);
    endtask

    task automatic push_resp(input logic [7:0] b);
        resp_q.push_back(b);
    endtask

    task automatic drain(input string tag);
        logic [7:0] r;
        logic [7:0] e;
        while (resp_q.size() != 0) begin
            spi_xfer(8'hFF, r);
            e = resp_q.pop_front();
            check(tag, {24'd0, r}, {24'd0, e});
        end
    endtask

    task automatic init_seq();
        push_resp(8'hFF); push_resp(8'h01);
        send_cmd(6'd55, 32'h0, 8'h65); drain("cmd55_a");
        push_resp(8'hFF); push_resp(8'h01);
        send_cmd(6'd41, 32'h4000_0000, 8'h77); drain("acmd41_a");
        check("init_done_after_first_acmd41", {31'd0, init_done}, 32'd0);
        push_resp(8'hFF); push_resp(8'h01);
        send_cmd(6'd55, 32'h0, 8'h65); drain("cmd55_b");
        push_resp(8'hFF); push_resp(8'h00);
        send_cmd(6'd41, 32'h4000_0000, 8'h77); drain("acmd41_b");
        check("init_done_after_second_acmd41", {31'd0, init_done}, 32'd1);
    endtask

    task automatic expect_cmd58();
        push_resp(8'hFF); push_resp(8'h00); push_resp(8'hC0);
        push_resp(8'hFF); push_resp(8'h80); push_resp(8'h00);
        send_cmd(6'd58, 32'h0, 8'hFD); drain("cmd58");
    endtask

    initial begin
        #20_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (5) @(negedge clk);
        check("rst_miso", {31'd0, miso}, 32'd1);
        check("rst_wr_addr", wr_addr, 32'd0);
        check("rst_wr_data", {24'd0, wr_data}, 32'd0);
        check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        check("rst_block_done", {31'd0, block_done}, 32'd0);
        check("rst_init_done", {31'd0, init_done}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        ss = 1'b0;
        repeat (10) @(negedge clk);

        push_resp(8'hFF); push_resp(8'h01);
        send_cmd(6'd0, 32'h0, 8'h95); drain("cmd0");
        check("init_done_after_cmd0", {31'd0, init_done}, 32'd0);

        push_resp(8'hFF); push_resp(8'h01); push_resp(8'h00);
        push_resp(8'h00); push_resp(8'h01); push_resp(8'hAA);
        send_cmd(6'd8, 32'h0000_01AA, 8'h87); drain("cmd8");

        init_seq();
        expect_cmd58();

        // Full block write.
        push_resp(8'hFF); push_resp(8'h00);
        send_cmd(6'd24, 32'h0000_0010, 8'hFF); drain("cmd24_r1");
        send(8'hFF);
        send(8'hFE);
        for (int i = 0; i < 512; i++) begin
            wr_q.push_back(8'(i));
            send(8'(i));
        end
        send(8'hAB);
        send(8'hCD);
        push_resp(8'h05);
        for (int i = 0; i < 4; i++) push_resp(8'h00);
        push_resp(8'hFF);
        drain("data_resp_busy");
        check("block_strobes", strobes, 32'd512);
        check("block_done_count", dones, 32'd1);
        check("wr_addr_block", wr_addr, 32'h10);

        push_resp(8'hFF); push_resp(8'h04);
        send_cmd(6'd17, 32'h0, 8'hFF); drain("cmd17_ready");
        push_resp(8'hFF); push_resp(8'h04);
        send_cmd(6'd41, 32'h0, 8'hFF); drain("cmd41_no_app");

        // Back to idle: writes must be refused.
        push_resp(8'hFF); push_resp(8'h01);
        send_cmd(6'd0, 32'h0, 8'h95); drain("cmd0_again");
        check("init_done_cleared", {31'd0, init_done}, 32'd0);
        push_resp(8'hFF); push_resp(8'h01);
        send_cmd(6'd24, 32'h0000_0030, 8'hFF); drain("cmd24_idle");
        send(8'hFF); send(8'hFE); send(8'h11); send(8'h22); send(8'h33);
        repeat (20) @(negedge clk);
        check("no_strobes_when_idle", strobes, 32'd512);
        check("wr_addr_unchanged", wr_addr, 32'h10);
        push_resp(8'hFF); push_resp(8'h05);
        send_cmd(6'd17, 32'h0, 8'hFF); drain("cmd17_idle");

        // Partial block aborted by deselect.
        init_seq();
        push_resp(8'hFF); push_resp(8'h00);
        send_cmd(6'd24, 32'h0000_0020, 8'hFF); drain("cmd24_b_r1");
        send(8'hFF);
        send(8'hFE);
        for (int i = 0; i < 100; i++) begin
            wr_q.push_back(8'(i * 7 + 3));
            send(8'(i * 7 + 3));
        end
        repeat (20) @(negedge clk);
        ss = 1'b1;
        repeat (10) @(negedge clk);
        check("miso_deselected", {31'd0, miso}, 32'd1);
        check("partial_strobes", strobes, 32'd612);
        check("partial_no_block_done", dones, 32'd1);
        check("wr_addr_partial", wr_addr, 32'h20);
        ss = 1'b0;
        repeat (10) @(negedge clk);
        expect_cmd58();
        check("init_done_kept", {31'd0, init_done}, 32'd1);

        check("extra_strobes", extra_strobes, 32'd0);
        check("wr_q_empty", wr_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
